// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// mux select codes, instruction classes and trap causes.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] RS2_REG  = 2'd0;
  localparam logic [1:0] RS2_FOUR = 2'd1;
  localparam logic [1:0] RS2_IMM  = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;
  localparam logic [1:0] PC_TRAP  = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  typedef enum logic [3:0] {
    CL_R       = 4'd0,
    CL_OPIMM   = 4'd1,
    CL_LOAD    = 4'd2,
    CL_STORE   = 4'd3,
    CL_BRANCH  = 4'd4,
    CL_JAL     = 4'd5,
    CL_JALR    = 4'd6,
    CL_LUI     = 4'd7,
    CL_AUIPC   = 4'd8,
    CL_SYSTEM  = 4'd9,
    CL_ILLEGAL = 4'd10
  } iclass_t;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL = 2'd0,
    CAUSE_SYSTEM  = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } cause_t;

  function automatic iclass_t decode_opcode(input logic [6:0] op);
    case (op)
      OP_R:      return CL_R;
      OP_IMM:    return CL_OPIMM;
      OP_LOAD:   return CL_LOAD;
      OP_STORE:  return CL_STORE;
      OP_BRANCH: return CL_BRANCH;
      OP_JAL:    return CL_JAL;
      OP_JALR:   return CL_JALR;
      OP_LUI:    return CL_LUI;
      OP_AUIPC:  return CL_AUIPC;
      OP_SYSTEM: return CL_SYSTEM;
      default:   return CL_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/rv_branch_cond.sv
// Branch resolution: maps func3 and comparator flags {ltu, lt, eq} to a taken
// decision; flags the two func3 codes that are not valid branches.
module rv_branch_cond (
  input  logic [2:0] func3,
  input  logic [2:0] compare,
  output logic       taken,
  output logic       bad_func3
);

  logic eq_s;
  logic lt_s;
  logic ltu_s;

  assign eq_s  = compare[0];
  assign lt_s  = compare[1];
  assign ltu_s = compare[2];

  // Condition select by func3; odd codes invert the even-code condition.
  always_comb begin
    taken     = 1'b0;
    bad_func3 = 1'b0;
    case (func3)
      3'b000:  taken = eq_s;
      3'b001:  taken = ~eq_s;
      3'b100:  taken = lt_s;
      3'b101:  taken = ~lt_s;
      3'b110:  taken = ltu_s;
      3'b111:  taken = ~ltu_s;
      default: bad_func3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, waits on the
// memory ready handshake with a timeout, and raises one-cycle traps.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter bit          TRAP_EN     = 1'b1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [2:0] compare,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       s_rs1,
  output logic [1:0] s_rs2,
  output logic       s_func3,
  output logic [1:0] s_pc,
  output logic [1:0] s_wb,
  output logic       branch,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  // A timeout of 0 disables trapping, so the counter then saturates at all-ones.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = (MEM_TIMEOUT == 0) ? {CNT_W{1'b1}} : CNT_W'(MEM_TIMEOUT);

  state_t           state_r;
  state_t           next_state_s;
  iclass_t          class_r;
  iclass_t          dec_class_s;
  cause_t           cause_r;
  cause_t           next_cause_s;
  logic [CNT_W-1:0] cnt_r;
  logic             taken_s;
  logic             bad_func3_s;
  logic             timeout_s;
  logic             waiting_s;

  rv_branch_cond u_branch_cond (
    .func3     (func3),
    .compare   (compare),
    .taken     (taken_s),
    .bad_func3 (bad_func3_s)
  );

  assign dec_class_s = decode_opcode(opcode);
  assign waiting_s   = ((state_r == S_FETCH) || (state_r == S_MEM)) && !mem_ready;
  assign timeout_s   = (MEM_TIMEOUT != 0) && waiting_s && (cnt_r == CNT_LAST);

  // State, latched class and trap cause registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= S_FETCH;
      class_r <= CL_ILLEGAL;
      cause_r <= CAUSE_ILLEGAL;
    end else begin
      state_r <= next_state_s;
      class_r <= (state_r == S_DECODE) ? dec_class_s : class_r;
      cause_r <= (next_state_s == S_TRAP) ? next_cause_s : cause_r;
    end
  end

  // Memory wait counter: counts stalled FETCH/MEM cycles, zero otherwise.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r <= '0;
    end else if (waiting_s) begin
      cnt_r <= (cnt_r != CNT_SAT) ? cnt_r + 1'b1 : cnt_r;
    end else begin
      cnt_r <= '0;
    end
  end

  // Next-state and control output decode.
  always_comb begin
    next_state_s = S_FETCH;
    next_cause_s = CAUSE_ILLEGAL;
    pc_write     = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    s_rs1        = 1'b0;
    s_rs2        = RS2_REG;
    s_func3      = 1'b0;
    s_pc         = PC_PLUS4;
    s_wb         = WB_ALU;
    branch       = 1'b0;
    trap         = 1'b0;
    trap_cause   = 2'd0;
    state        = 3'd0;
    if (clr) begin
      next_state_s = S_FETCH;
    end else begin
      state = state_r;
      case (state_r)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write     = 1'b1;
            next_state_s = S_DECODE;
          end else if (timeout_s && TRAP_EN) begin
            next_state_s = S_TRAP;
            next_cause_s = CAUSE_TIMEOUT;
          end else begin
            next_state_s = S_FETCH;
          end
        end
        S_DECODE: begin
          if (dec_class_s != CL_ILLEGAL) begin
            next_state_s = S_EXEC;
          end else if (TRAP_EN) begin
            next_state_s = S_TRAP;
            next_cause_s = CAUSE_ILLEGAL;
          end else begin
            pc_write     = 1'b1;
            next_state_s = S_FETCH;
          end
        end
        S_EXEC: begin
          case (class_r)
            CL_R: begin
              s_func3      = 1'b1;
              next_state_s = S_WB;
            end
            CL_OPIMM: begin
              s_rs2        = RS2_IMM;
              s_func3      = 1'b1;
              next_state_s = S_WB;
            end
            CL_LOAD, CL_STORE: begin
              s_rs2        = RS2_IMM;
              next_state_s = S_MEM;
            end
            CL_BRANCH: begin
              branch = 1'b1;
              // Reserved func3 traps before touching the PC.
              if (!bad_func3_s) begin
                pc_write     = 1'b1;
                s_pc         = taken_s ? PC_IMM : PC_PLUS4;
                next_state_s = S_FETCH;
              end else if (TRAP_EN) begin
                next_state_s = S_TRAP;
                next_cause_s = CAUSE_ILLEGAL;
              end else begin
                pc_write     = 1'b1;
                next_state_s = S_FETCH;
              end
            end
            CL_JAL, CL_JALR, CL_LUI: begin
              next_state_s = S_WB;
            end
            CL_AUIPC: begin
              s_rs1        = 1'b1;
              s_rs2        = RS2_IMM;
              next_state_s = S_WB;
            end
            CL_SYSTEM: begin
              if (TRAP_EN) begin
                next_state_s = S_TRAP;
                next_cause_s = CAUSE_SYSTEM;
              end else begin
                pc_write     = 1'b1;
                next_state_s = S_FETCH;
              end
            end
            default: begin
              next_state_s = S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_write = (class_r == CL_STORE);
          mem_read  = (class_r != CL_STORE);
          if (mem_ready) begin
            if (class_r == CL_STORE) begin
              pc_write     = 1'b1;
              next_state_s = S_FETCH;
            end else begin
              next_state_s = S_WB;
            end
          end else if (timeout_s && TRAP_EN) begin
            next_state_s = S_TRAP;
            next_cause_s = CAUSE_TIMEOUT;
          end else begin
            next_state_s = S_MEM;
          end
        end
        S_WB: begin
          reg_write    = 1'b1;
          pc_write     = 1'b1;
          next_state_s = S_FETCH;
          case (class_r)
            CL_LOAD: s_wb = WB_MEM;
            CL_JAL: begin
              s_wb = WB_PC4;
              s_pc = PC_IMM;
            end
            CL_JALR: begin
              s_wb  = WB_PC4;
              s_pc  = PC_ALU;
              s_rs2 = RS2_IMM;
            end
            CL_LUI:  s_wb = WB_IMM;
            default: s_wb = WB_ALU;
          endcase
        end
        S_TRAP: begin
          trap         = 1'b1;
          pc_write     = 1'b1;
          s_pc         = PC_TRAP;
          trap_cause   = cause_r;
          next_state_s = S_FETCH;
        end
        default: begin
          next_state_s = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: a trace-building reference model
// predicts every cycle's outputs for randomized instructions and memory stalls.
module tb_rv_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       s_rs1;
    logic [1:0] s_rs2;
    logic       s_func3;
    logic [1:0] s_pc;
    logic [1:0] s_wb;
    logic       branch;
    logic       trap;
    logic [1:0] trap_cause;
  } out_t;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       clr;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [2:0] compare;
  logic       mem_ready;

  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, s_rs1, s_func3, branch, trap;
  logic [1:0] s_rs2, s_pc, s_wb, trap_cause;
  logic [2:0] state;
  logic       pc_write_n, i_or_d_n, mem_read_n, mem_write_n, ir_write_n, reg_write_n, s_rs1_n, s_func3_n, branch_n, trap_n;
  logic [1:0] s_rs2_n, s_pc_n, s_wb_n, trap_cause_n;
  logic [2:0] state_n;

  out_t act_s;
  out_t act_n;
  out_t exp_q[$];
  bit   rdy_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rv_multicycle_ctrl dut (
    .clk(clk), .clr(clr), .opcode(opcode), .func3(func3), .compare(compare), .mem_ready(mem_ready),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .s_rs1(s_rs1), .s_rs2(s_rs2), .s_func3(s_func3),
    .s_pc(s_pc), .s_wb(s_wb), .branch(branch), .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  rv_multicycle_ctrl #(.MEM_TIMEOUT(15), .TRAP_EN(1'b0), .CNT_W(4)) dut_nt (
    .clk(clk), .clr(clr), .opcode(opcode), .func3(func3), .compare(compare), .mem_ready(mem_ready),
    .pc_write(pc_write_n), .i_or_d(i_or_d_n), .mem_read(mem_read_n), .mem_write(mem_write_n),
    .ir_write(ir_write_n), .reg_write(reg_write_n), .s_rs1(s_rs1_n), .s_rs2(s_rs2_n), .s_func3(s_func3_n),
    .s_pc(s_pc_n), .s_wb(s_wb_n), .branch(branch_n), .trap(trap_n), .trap_cause(trap_cause_n), .state(state_n)
  );

  assign act_s = {state, pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, s_rs1,
                  s_rs2, s_func3, s_pc, s_wb, branch, trap, trap_cause};
  assign act_n = {state_n, pc_write_n, i_or_d_n, mem_read_n, mem_write_n, ir_write_n, reg_write_n, s_rs1_n,
                  s_rs2_n, s_func3_n, s_pc_n, s_wb_n, branch_n, trap_n, trap_cause_n};

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic out_t st(input int s);
    out_t o;
    o       = '0;
    o.state = 3'(s);
    return o;
  endfunction

  function automatic void push(input out_t o, input bit r);
    exp_q.push_back(o);
    rdy_q.push_back(r);
  endfunction

  function automatic void push_trap(input int cause);
    out_t o;
    o            = st(5);
    o.trap       = 1'b1;
    o.pc_write   = 1'b1;
    o.s_pc       = 2'd3;
    o.trap_cause = 2'(cause);
    push(o, rb());
  endfunction

  // One memory access of `waits` stall cycles; returns 1 when it ends in a timeout trap.
  function automatic bit mem_phase(input int s, input bit fetch, input bit store, input int waits, input bit trap_en);
    out_t o;
    int   n;
    o = st(s);
    if (fetch) o.mem_read = 1'b1;
    else begin
      o.i_or_d    = 1'b1;
      o.mem_read  = !store;
      o.mem_write = store;
    end
    n = (trap_en && waits >= TIMEOUT) ? TIMEOUT : waits;
    for (int i = 0; i < n; i++) push(o, 1'b0);
    if (trap_en && waits >= TIMEOUT) begin
      push_trap(2);
      return 1'b1;
    end
    if (fetch) o.ir_write = 1'b1;
    if (store) o.pc_write = 1'b1;
    push(o, 1'b1);
    return 1'b0;
  endfunction

  function automatic void push_wb(input logic [1:0] wbsel, input logic [1:0] pcsel, input bit jalr);
    out_t o;
    o           = st(4);
    o.reg_write = 1'b1;
    o.pc_write  = 1'b1;
    o.s_wb      = wbsel;
    o.s_pc      = pcsel;
    if (jalr) o.s_rs2 = 2'd2;
    push(o, rb());
  endfunction

  function automatic int kind_of(input logic [6:0] op);
    case (op)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      7'b1101111: return 5;
      7'b1100111: return 6;
      7'b0110111: return 7;
      7'b0010111: return 8;
      7'b1110011: return 9;
      default:    return 10;
    endcase
  endfunction

  // Expected per-cycle trace for one instruction with operands a/b feeding the comparator.
  function automatic void build(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input int wf, input int wm);
    out_t o;
    int   k;
    bit   tk;
    bit   bad;
    k = kind_of(op);
    if (mem_phase(0, 1'b1, 1'b0, wf, 1'b1)) return;
    push(st(1), rb());
    if (k == 10) begin
      push_trap(0);
      return;
    end
    o = st(2);
    case (k)
      0: begin o.s_func3 = 1'b1; push(o, rb()); push_wb(2'd0, 2'd0, 1'b0); end
      1: begin o.s_func3 = 1'b1; o.s_rs2 = 2'd2; push(o, rb()); push_wb(2'd0, 2'd0, 1'b0); end
      2: begin
        o.s_rs2 = 2'd2;
        push(o, rb());
        if (!mem_phase(3, 1'b0, 1'b0, wm, 1'b1)) push_wb(2'd1, 2'd0, 1'b0);
      end
      3: begin
        o.s_rs2 = 2'd2;
        push(o, rb());
        void'(mem_phase(3, 1'b0, 1'b1, wm, 1'b1));
      end
      4: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          default: tk = (a >= b);
        endcase
        bad      = (f3 == 3'd2) || (f3 == 3'd3);
        o.branch = 1'b1;
        if (bad) begin
          push(o, rb());
          push_trap(0);
        end else begin
          o.pc_write = 1'b1;
          o.s_pc     = tk ? 2'd1 : 2'd0;
          push(o, rb());
        end
      end
      5: begin push(o, rb()); push_wb(2'd2, 2'd1, 1'b0); end
      6: begin push(o, rb()); push_wb(2'd2, 2'd2, 1'b1); end
      7: begin push(o, rb()); push_wb(2'd3, 2'd0, 1'b0); end
      8: begin o.s_rs1 = 1'b1; o.s_rs2 = 2'd2; push(o, rb()); push_wb(2'd0, 2'd0, 1'b0); end
      default: begin push(o, rb()); push_trap(1); end
    endcase
  endfunction

  // Replays the queued trace; entered and left just after a rising edge.
  task automatic run_trace(input string name, input bit use_n);
    out_t e;
    out_t a;
    int   cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e         = exp_q.pop_front();
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      a = use_n ? act_n : act_s;
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h (op=%b f3=%b cmp=%b rdy=%b)",
                 name, cyc, a, e, opcode, func3, compare, mem_ready);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input int wf, input int wm);
    exp_q.delete();
    rdy_q.delete();
    opcode  = op;
    func3   = f3;
    compare = {a < b, $signed(a) < $signed(b), a == b};
    build(op, f3, a, b, wf, wm);
    run_trace(name, 1'b0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr       = 1'b1;
    opcode    = 7'($urandom);
    func3     = 3'($urandom);
    compare   = 3'($urandom);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if (act_s !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", act_s);
    end
    n_tests++;
    if (act_n !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_nt: got %h expected 0", act_n);
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_add();
    do_instr("add", 7'b0110011, 3'b000, 32'd3, 32'd4, 0, 0);
  endtask

  task automatic test_branch();
    do_instr("beq_taken", 7'b1100011, 3'b000, 32'd5, 32'd5, 0, 0);
    do_instr("beq_not_taken", 7'b1100011, 3'b000, 32'd9, 32'd7, 0, 0);
    do_instr("blt_signed", 7'b1100011, 3'b100, 32'hFFFF_FFFF, 32'd1, 0, 0);
    do_instr("bltu_unsigned", 7'b1100011, 3'b110, 32'hFFFF_FFFF, 32'd1, 0, 0);
    do_instr("branch_bad_func3", 7'b1100011, 3'b011, 32'd1, 32'd1, 0, 0);
  endtask

  task automatic test_load_wait();
    do_instr("lw_wait3", 7'b0000011, 3'b010, 32'd0, 32'd0, 0, 3);
    do_instr("sw_wait2", 7'b0100011, 3'b010, 32'd0, 32'd0, 1, 2);
  endtask

  task automatic test_traps();
    do_instr("illegal_op", 7'b0000000, 3'b000, 32'd0, 32'd0, 0, 0);
    do_instr("system", 7'b1110011, 3'b000, 32'd0, 32'd0, 0, 0);
    do_instr("fetch_timeout", 7'b0110011, 3'b000, 32'd0, 32'd0, 15, 0);
    do_instr("fetch_ready_at_limit", 7'b0110011, 3'b000, 32'd0, 32'd0, 14, 0);
    do_instr("load_timeout", 7'b0000011, 3'b010, 32'd0, 32'd0, 0, 15);
    do_instr("store_ready_at_limit", 7'b0100011, 3'b010, 32'd0, 32'd0, 0, 14);
  endtask

  // Trap-disabled instance: illegal and SYSTEM advance PC+4, timeouts keep waiting.
  task automatic test_trap_disabled();
    out_t o;
    pulse_clr();
    exp_q.delete();
    rdy_q.delete();
    opcode  = 7'b0000000;
    func3   = 3'b000;
    compare = 3'b000;
    void'(mem_phase(0, 1'b1, 1'b0, 0, 1'b0));
    o = st(1); o.pc_write = 1'b1; push(o, rb());
    run_trace("nt_illegal", 1'b1);
    opcode = 7'b1110011;
    void'(mem_phase(0, 1'b1, 1'b0, 0, 1'b0));
    push(st(1), rb());
    o = st(2); o.pc_write = 1'b1; push(o, rb());
    run_trace("nt_system", 1'b1);
    opcode = 7'b0110011;
    void'(mem_phase(0, 1'b1, 1'b0, 20, 1'b0));
    push(st(1), rb());
    o = st(2); o.s_func3 = 1'b1; push(o, rb());
    push_wb(2'd0, 2'd0, 1'b0);
    run_trace("nt_fetch_no_timeout", 1'b1);
    pulse_clr();
  endtask

  task automatic test_clr_mid_store();
    exp_q.delete();
    rdy_q.delete();
    opcode  = 7'b0100011;
    func3   = 3'b010;
    compare = 3'b000;
    build(opcode, func3, 32'd0, 32'd0, 0, 10);
    while (exp_q.size() > 5) begin
      void'(exp_q.pop_back());
      void'(rdy_q.pop_back());
    end
    run_trace("sw_before_clr", 1'b0);
    clr       = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (act_s !== '0) begin
      n_fail++;
      $display("FAIL clr_in_mem: got %h expected 0 (mem_write=%b)", act_s, mem_write);
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
    do_instr("restart_after_clr", 7'b0010011, 3'b000, 32'd0, 32'd0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [12];
    int         waits [8];
    logic [31:0] a, b;
    ops   = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
              7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0000000, 7'b0001111};
    waits = '{0, 0, 0, 1, 2, 3, 14, 15};
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      do_instr("random", ops[$urandom_range(0, 11)], 3'($urandom), a, b,
               waits[$urandom_range(0, 7)], waits[$urandom_range(0, 7)]);
    end
  endtask

  initial begin
    clr       = 1'b1;
    opcode    = 7'd0;
    func3     = 3'd0;
    compare   = 3'd0;
    mem_ready = 1'b0;
    test_reset();
    test_add();
    test_branch();
    test_load_wait();
    test_traps();
    test_trap_disabled();
    test_clr_mid_store();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
